// File: rtl/fetch_prefetch_queue.sv
// Decoupled instruction-fetch front end: sequential fetch with one outstanding request,
// DEPTH-entry {PC, instruction} queue towards decode, and redirect flush.
module fetch_prefetch_queue #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic                     CLK,
  input  logic                     RES,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirectAddr,
  output logic                     imemReq,
  output logic [XLEN-1:0]          imemAddr,
  input  logic                     imemValid,
  input  logic [XLEN-1:0]          imemData,
  output logic                     instValid,
  input  logic                     instReady,
  output logic [XLEN-1:0]          inst,
  output logic [XLEN-1:0]          instPC,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] fetchPc_r;
  logic [XLEN-1:0] reqPc_r;
  logic [PW-1:0]   rdPtr_r;
  logic [PW-1:0]   wrPtr_r;
  logic [CW-1:0]   count_r;
  logic            pending_r;
  logic            discard_r;
  logic [XLEN-1:0] instMem_r [DEPTH];
  logic [XLEN-1:0] pcMem_r [DEPTH];

  logic full_s;
  logic notEmpty_s;
  logic respTaken_s;
  logic push_s;
  logic pop_s;

  assign full_s      = (count_r == CW'(DEPTH));
  assign notEmpty_s  = (count_r != {CW{1'b0}});
  // A response only counts while a fetch is outstanding; stray strobes are ignored.
  assign respTaken_s = imemValid & pending_r;
  assign push_s      = respTaken_s & ~discard_r & ~redirect & ~RES;
  assign pop_s       = notEmpty_s & instReady & ~redirect & ~RES;

  assign imemReq   = ~RES & ~redirect & ~pending_r & ~full_s;
  assign imemAddr  = fetchPc_r;
  assign instValid = ~RES & notEmpty_s;
  assign inst      = instMem_r[rdPtr_r];
  assign instPC    = pcMem_r[rdPtr_r];
  assign occupancy = RES ? {CW{1'b0}} : count_r;

  // Queue storage; contents are don't-care until a push makes an entry valid.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      instMem_r[wrPtr_r] <= imemData;
      pcMem_r[wrPtr_r]   <= reqPc_r;
    end
  end

  // Fetch control, pointers and occupancy; redirect flushes and may arm a discard.
  always_ff @(posedge CLK) begin
    if (RES) begin
      fetchPc_r <= RESET_PC;
      reqPc_r   <= RESET_PC;
      rdPtr_r   <= {PW{1'b0}};
      wrPtr_r   <= {PW{1'b0}};
      count_r   <= {CW{1'b0}};
      pending_r <= 1'b0;
      discard_r <= 1'b0;
    end else if (redirect) begin
      fetchPc_r <= redirectAddr;
      rdPtr_r   <= {PW{1'b0}};
      wrPtr_r   <= {PW{1'b0}};
      count_r   <= {CW{1'b0}};
      if (pending_r && !imemValid) begin
        discard_r <= 1'b1;
      end else begin
        pending_r <= 1'b0;
        discard_r <= 1'b0;
      end
    end else begin
      if (imemReq) begin
        pending_r <= 1'b1;
        reqPc_r   <= fetchPc_r;
        fetchPc_r <= fetchPc_r + PC_STEP;
      end else if (respTaken_s) begin
        pending_r <= 1'b0;
        discard_r <= 1'b0;
      end
      if (push_s) begin
        wrPtr_r <= wrPtr_r + PW'(1);
      end
      if (pop_s) begin
        rdPtr_r <= rdPtr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
